// File: rtl/ram_arbiter_rr_if.sv
// Bundle of the per-CPU cache channels and the shared RAM port for ram_arbiter_rr.
// The master side is the caches plus the RAM model; the slave side is the arbiter.
interface ram_arbiter_rr_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    localparam int IDW = $clog2(2 * CPUS);

    logic [CPUS-1:0]        iREN;
    logic [CPUS*ADDR_W-1:0] iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*ADDR_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] dload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [ADDR_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;
    logic                   gnt_valid;
    logic [IDW-1:0]         gnt_id;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
        input  gnt_valid, gnt_id
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
        output gnt_valid, gnt_id
    );
endinterface

// File: rtl/ram_arbiter_rr.sv
// Registered round-robin arbiter sharing one RAM port among 2*CPUS cache channels.
// Define ARB_DCACHE_PRIO_EN to make any dcache request beat every icache request.
module ram_arbiter_rr #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    ram_arbiter_rr_if.slave  bus
);
    localparam int N   = 2 * CPUS;
    localparam int IDW = $clog2(N);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    gntId_q, gntId_d;
    logic [IDW-1:0]    last_q, last_d;

    logic [N-1:0]      req;
    logic [N-1:0]      scanMask;
    logic [IDW-1:0]    winner;
    logic              found;
    logic              grantIsD;
    logic              grantReq;
    logic              complete;
    logic [ADDR_W-1:0] selIaddr, selDaddr;
    logic [WORD_W-1:0] selDstore;
    logic              selDwen;
    logic              ramRenC, ramWenC;
    logic [ADDR_W-1:0] ramAddrC;
    logic [WORD_W-1:0] ramStoreC;
    logic [CPUS-1:0]   iwaitC, dwaitC;

    always_comb begin
        req = '0;
        for (int k = 0; k < CPUS; k++) begin
            req[2*k]   = bus.dREN[k] | bus.dWEN[k];
            req[2*k+1] = bus.iREN[k];
        end
    end

    // Scan starts just after the last completed channel so it ends up lowest priority.
    always_comb begin
        scanMask = req;
`ifdef ARB_DCACHE_PRIO_EN
        begin
            logic [N-1:0] dMask;
            dMask = '0;
            for (int k = 0; k < CPUS; k++) begin
                dMask[2*k] = req[2*k];
            end
            if (|dMask) begin
                scanMask = dMask;
            end
        end
`endif
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && scanMask[IDW'((int'(last_q) + i) % N)]) begin
                winner = IDW'((int'(last_q) + i) % N);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        selIaddr  = '0;
        selDaddr  = '0;
        selDstore = '0;
        selDwen   = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            if (int'(gntId_q) / 2 == k) begin
                selIaddr  = bus.iaddr[k*ADDR_W +: ADDR_W];
                selDaddr  = bus.daddr[k*ADDR_W +: ADDR_W];
                selDstore = bus.dstore[k*WORD_W +: WORD_W];
                selDwen   = bus.dWEN[k];
            end
        end
    end

    assign grantIsD = ~gntId_q[0];
    assign grantReq = req[gntId_q];

    // The RAM command tracks the live dcache inputs, so a read can turn into a write mid-grant.
    always_comb begin
        state_d   = state_q;
        gntId_d   = gntId_q;
        last_d    = last_q;
        complete  = 1'b0;
        ramRenC   = 1'b0;
        ramWenC   = 1'b0;
        ramAddrC  = '0;
        ramStoreC = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gntId_d = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ramAddrC = grantIsD ? selDaddr : selIaddr;
                if (grantIsD && selDwen) begin
                    ramWenC   = 1'b1;
                    ramStoreC = selDstore;
                end else begin
                    ramRenC = 1'b1;
                end
                if (!grantReq) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    complete = 1'b1;
                    last_d   = gntId_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwaitC = '0;
        dwaitC = '0;
        for (int k = 0; k < CPUS; k++) begin
            dwaitC[k] = req[2*k]   & ~(complete && (gntId_q == IDW'(2*k)));
            iwaitC[k] = req[2*k+1] & ~(complete && (gntId_q == IDW'(2*k+1)));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gntId_q <= '0;
            last_q  <= IDW'(N - 1);
        end else begin
            state_q <= state_d;
            gntId_q <= gntId_d;
            last_q  <= last_d;
        end
    end

    assign bus.ramREN    = ramRenC;
    assign bus.ramWEN    = ramWenC;
    assign bus.ramaddr   = ramAddrC;
    assign bus.ramstore  = ramStoreC;
    assign bus.iwait     = iwaitC;
    assign bus.dwait     = dwaitC;
    assign bus.iload     = {CPUS{bus.ramload}};
    assign bus.dload     = {CPUS{bus.ramload}};
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.gnt_id    = gntId_q;
endmodule
